if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage miniRV pipeline.
//   - Owns the PC register and drives the instruction-ROM address.
//   - Captures the fetched word into the IF/ID pipeline register, which feeds
//     the decode stage (id_inst -> decode din, id_pc4 -> decode npc_pc4).
//   - Applies stall from the hazard unit and redirect (taken branch/jump) from EX.
//   - Halts on a misaligned redirect target.

---
 rtl/if_stage_if.sv | 48 ++++
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundle of fetch-stage signals: IROM port, hazard/redirect controls and the
// IF/ID pipeline register outputs. The fetch stage takes the master side.
interface if_stage_if #(
    parameter int unsigned IROM_AW = 14
);
    logic [IROM_AW-1:0] irom_adr;
    logic [31:0]        irom_inst;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        if_pc;
    logic [31:0]        id_inst;
    logic [31:0]        id_pc;
    logic [31:0]        id_pc4;
    logic               id_valid;
    logic               if_halt;
    logic [31:0]        err_pc;

    modport master (
        output irom_adr,
        input  irom_inst,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output if_pc,
        output id_inst,
        output id_pc,
        output id_pc4,
        output id_valid,
        output if_halt,
        output err_pc
    );

    modport slave (
        input  irom_adr,
        output irom_inst,
        output stall,
        output redirect,
        output redirect_pc,
        input  if_pc,
        input  id_inst,
        input  id_pc,
        input  id_pc4,
        input  id_valid,
        input  if_halt,
        input  err_pc
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the miniRV pipeline: PC register, IROM address,
// IF/ID pipeline register, stall/redirect handling and halt on a misaligned
// redirect target.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IROM_AW  = 14,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic       clk,
    input logic       rst,
    if_stage_if.master bus
);
    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] id_inst, id_inst_n;
    logic [31:0] id_pc, id_pc_n;
    logic [31:0] id_pc4, id_pc4_n;
    logic        id_valid, id_valid_n;
    logic [31:0] err_pc, err_pc_n;
    logic [31:0] pc_plus4;

    assign pc_plus4     = pc + 32'd4;
    assign bus.irom_adr = pc[IROM_AW+1:2];
    assign bus.if_pc    = pc;
    assign bus.id_inst  = id_inst;
    assign bus.id_pc    = id_pc;
    assign bus.id_pc4   = id_pc4;
    assign bus.id_valid = id_valid;
    assign bus.if_halt  = (state == HALT);
    assign bus.err_pc   = err_pc;

    // Next-state and next IF/ID contents; priority redirect > stall > advance.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        id_inst_n  = id_inst;
        id_pc_n    = id_pc;
        id_pc4_n   = id_pc4;
        id_valid_n = id_valid;
        err_pc_n   = err_pc;
        unique case (state)
            RUN: begin
                if (bus.redirect) begin
                    id_inst_n  = NOP_INST;
                    id_pc_n    = '0;
                    id_pc4_n   = '0;
                    id_valid_n = 1'b0;
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        state_n  = HALT;
                        err_pc_n = bus.redirect_pc;
                    end else begin
                        pc_n = bus.redirect_pc;
                    end
                end else if (!bus.stall) begin
                    id_inst_n  = bus.irom_inst;
                    id_pc_n    = pc;
                    id_pc4_n   = pc_plus4;
                    id_valid_n = 1'b1;
                    pc_n       = pc_plus4;
                end
            end
            HALT: begin
                id_inst_n  = NOP_INST;
                id_pc_n    = '0;
                id_pc4_n   = '0;
                id_valid_n = 1'b0;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            id_inst  <= NOP_INST;
            id_pc    <= '0;
            id_pc4   <= '0;
            id_valid <= 1'b0;
            err_pc   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            id_inst  <= id_inst_n;
            id_pc    <= id_pc_n;
            id_pc4   <= id_pc4_n;
            id_valid <= id_valid_n;
            err_pc   <= err_pc_n;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural fetch model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_w = 1'b1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] irom [0:16383];

    if_stage_if #(.IROM_AW(14)) bus ();
    if_stage_if #(.IROM_AW(14)) wbus ();

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .IROM_AW (14),
        .NOP_INST(NOP)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    if_stage #(
        .RESET_PC(32'hFFFF_FFFC),
        .IROM_AW (14),
        .NOP_INST(NOP)
    ) u_wrap (
        .clk(clk),
        .rst(rst_w),
        .bus(wbus.master)
    );

    always #5 clk = ~clk;

    // Combinational IROM shared by both instances.
    always_comb begin
        bus.irom_inst  = irom[bus.irom_adr];
        wbus.irom_inst = irom[wbus.irom_adr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC, halt flag and IF/ID contents by the fetch rules.
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_inst, m_ipc, m_pc4, m_err;
    logic        m_valid, m_halt;

    task automatic m_bubble();
        m_inst  = NOP;
        m_ipc   = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'd0; m_halt = 1'b0; m_err = 32'd0; m_known = 1'b1;
            m_bubble();
        end else if (m_known) begin
            if (m_halt) begin
                m_bubble();
            end else if (bus.redirect && (bus.redirect_pc % 4 != 0)) begin
                m_halt = 1'b1;
                m_err  = bus.redirect_pc;
                m_bubble();
            end else if (bus.redirect) begin
                m_pc = bus.redirect_pc;
                m_bubble();
            end else if (!bus.stall) begin
                m_inst  = irom[m_pc[15:2]];
                m_ipc   = m_pc;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_known) begin
            check("m_if_pc",    bus.if_pc,              m_pc);
            check("m_irom_adr", 32'(bus.irom_adr),      {18'd0, m_pc[15:2]});
            check("m_id_inst",  bus.id_inst,            m_inst);
            check("m_id_pc",    bus.id_pc,              m_ipc);
            check("m_id_pc4",   bus.id_pc4,             m_pc4);
            check("m_id_valid", 32'(bus.id_valid),      32'(m_valid));
            check("m_if_halt",  32'(bus.if_halt),       32'(m_halt));
            check("m_err_pc",   bus.err_pc,             m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) irom[i] = 32'(i * 32'h0001_0000) | 32'h0000_0033;
        irom[0] = 32'h0050_0093;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
        wbus.stall = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = 32'd0;

        // 1: reset for two edges, then release
        tick(); tick();
        check("rst_valid", 32'(bus.id_valid), 32'd0);
        check("rst_inst",  bus.id_inst, 32'h13);
        check("rst_pc",    bus.if_pc, 32'd0);
        rst = 1'b0;
        tick();
        check("first_inst", bus.id_inst, 32'h0050_0093);
        check("first_pc",   bus.id_pc, 32'd0);
        check("first_pc4",  bus.id_pc4, 32'd4);
        check("first_ifpc", bus.if_pc, 32'd4);

        // 2: free-running sequence
        check("run_adr0", 32'(bus.irom_adr), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("run_idpc",  bus.id_pc, 32'(4 * k));
            check("run_valid", 32'(bus.id_valid), 32'd1);
            check("run_adr",   32'(bus.irom_adr), 32'(k + 1));
        end

        // 3: stall while if_pc=8
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        check("pre_stall_ifpc", bus.if_pc, 32'd8);
        bus.stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_idpc", bus.id_pc, 32'd4);
            check("stall_ifpc", bus.if_pc, 32'd8);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_idpc", bus.id_pc, 32'd8);
        check("unstall_ifpc", bus.if_pc, 32'hC);

        // 4: redirect wins over simultaneous stall
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100; bus.stall = 1'b1;
        tick();
        check("redir_ifpc",  bus.if_pc, 32'h100);
        check("redir_valid", 32'(bus.id_valid), 32'd0);
        check("redir_inst",  bus.id_inst, NOP);
        bus.redirect = 1'b0; bus.stall = 1'b0;
        tick();
        check("redir_idpc",  bus.id_pc, 32'h100);
        check("redir_pc4",   bus.id_pc4, 32'h104);
        check("redir_v1",    32'(bus.id_valid), 32'd1);
        check("redir_word",  bus.id_inst, 32'h0040_0033);

        // 5: misaligned redirect halts fetch
        bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
        tick();
        check("halt_flag",  32'(bus.if_halt), 32'd1);
        check("halt_err",   bus.err_pc, 32'h102);
        check("halt_valid", 32'(bus.id_valid), 32'd0);
        check("halt_ifpc",  bus.if_pc, 32'h104);
        bus.redirect_pc = 32'h200;
        for (int k = 0; k < 5; k++) begin
            bus.stall = k[0];
            bus.redirect = ~k[0];
            tick();
            check("halt_frozen", bus.if_pc, 32'h104);
            check("halt_bubble", 32'(bus.id_valid), 32'd0);
        end
        bus.stall = 1'b0; bus.redirect = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("unhalt_flag", 32'(bus.if_halt), 32'd0);
        check("unhalt_pc",   bus.if_pc, 32'd0);
        check("unhalt_err",  bus.err_pc, 32'd0);
        tick();
        check("unhalt_run", bus.id_pc4, 32'd4);

        // reset asserted together with stall and redirect
        tick();
        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h40; rst = 1'b1;
        tick();
        check("rst_mid_pc",    bus.if_pc, 32'd0);
        check("rst_mid_valid", 32'(bus.id_valid), 32'd0);
        bus.stall = 1'b0; bus.redirect = 1'b0; rst = 1'b0;
        tick(); tick();
        check("post_rst_idpc", bus.id_pc, 32'd4);

        // 6: PC wrap from 32'hFFFF_FFFC
        check("wrap_rst_pc", wbus.if_pc, 32'hFFFF_FFFC);
        rst_w = 1'b0;
        tick();
        check("wrap_idpc",  wbus.id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4",   wbus.id_pc4, 32'd0);
        check("wrap_ifpc",  wbus.if_pc, 32'd0);
        check("wrap_inst",  wbus.id_inst, 32'h3FFF_0033);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
